pulse_train_rx: RTL and testbench

Receiving end of the pulse-burst generator, i.e. the pwm pulse-train transmitter in this codebase. It samples an asynchronous pulse-train input in the sys_clk domain and counts its rising edges. It also measures the edge-to-edge period, detects end-of-burst by an idle timeout, and reports the count, the period and a match flag against the expected pulse count. It sits on the test/loopback side of the board, next to the pulse generator.

---
 rtl/pulse_rx_pkg.sv | 21 ++
 rtl/sync_rise_det.sv | 28 ++
 rtl/pulse_train_rx.sv | 124 ++++++++++++
 tb/tb_pulse_train_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_rx_pkg.sv
// Shared types and defaults for the pulse-train receiver.
// The saturating increment helper works on values up to 32 bits wide.
package pulse_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } rx_state_t;

    localparam int unsigned DEF_CNT_W        = 16;
    localparam int unsigned DEF_PER_W        = 26;
    localparam int unsigned DEF_IDLE_TIMEOUT = 100000;
    localparam int unsigned DEF_EXP_PULSES   = 2500;

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer followed by a previous-value register.
// Produces a one-cycle rise strobe for each low-to-high transition of sig.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= sig;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/pulse_train_rx.sv
// Pulse-train receiver: counts rising edges of a burst, measures the last
// edge-to-edge period and ends the burst after an idle timeout.
module pulse_train_rx
    import pulse_rx_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned PER_W        = DEF_PER_W,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int unsigned EXP_PULSES   = DEF_EXP_PULSES
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pulse_in,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [PER_W-1:0] period,
    output logic             match,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [PER_W-1:0] TIMER_MAX    = '1;
    localparam logic [PER_W-1:0] TIMEOUT_LAST = PER_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] EXP_CNT      = CNT_W'(EXP_PULSES);

    rx_state_t        state, state_n;
    logic [PER_W-1:0] timer, timer_n;
    logic [CNT_W-1:0] cnt_n;
    logic [PER_W-1:0] per_n;
    logic             match_n, ovf_n, busy_n, done_n;
    logic             rise;

    sync_rise_det u_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .sig  (pulse_in),
        .rise (rise)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            timer     <= '0;
            pulse_cnt <= '0;
            period    <= '0;
            match     <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            pulse_cnt <= cnt_n;
            period    <= per_n;
            match     <= match_n;
            overflow  <= ovf_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // done/busy/match are registered on the COUNT->DONE transition so they
    // are visible exactly during the single DONE cycle.
    always_comb begin
        state_n = state;
        timer_n = timer;
        cnt_n   = pulse_cnt;
        per_n   = period;
        match_n = match;
        ovf_n   = overflow;
        busy_n  = busy;
        done_n  = 1'b0;

        if (clr) begin
            state_n = IDLE;
            timer_n = '0;
            cnt_n   = '0;
            per_n   = '0;
            match_n = 1'b0;
            ovf_n   = 1'b0;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = COUNT;
                        cnt_n   = CNT_W'(1);
                        per_n   = '0;
                        timer_n = '0;
                        ovf_n   = 1'b0;
                        match_n = 1'b0;
                        busy_n  = 1'b1;
                    end
                end
                COUNT: begin
                    if (rise) begin
                        per_n   = PER_W'(sat_inc(32'(timer), 32'(TIMER_MAX)));
                        timer_n = '0;
                        cnt_n   = CNT_W'(sat_inc(32'(pulse_cnt), 32'(CNT_MAX)));
                        if (pulse_cnt == CNT_MAX) begin
                            ovf_n = 1'b1;
                        end
                    end else if (timer == TIMEOUT_LAST) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        match_n = (pulse_cnt == EXP_CNT) && !overflow;
                    end else begin
                        timer_n = PER_W'(sat_inc(32'(timer), 32'(TIMER_MAX)));
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_rx.sv
// Self-checking bench for pulse_train_rx: vector table, corner sequences
// and randomized bursts checked against a burst-level reference model.
module tb_pulse_train_rx;

    localparam int T   = 64;
    localparam int EXP = 4;
    localparam int CMAX_B = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic pulse_in = 1'b0;

    logic        busy_a, done_a, match_a, ovf_a;
    logic [15:0] cnt_a;
    logic [25:0] per_a;
    logic        busy_b, done_b, match_b, ovf_b;
    logic [2:0]  cnt_b;
    logic [25:0] per_b;

    pulse_train_rx #(.IDLE_TIMEOUT(T), .EXP_PULSES(EXP)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .pulse_in(pulse_in), .clr(clr),
        .busy(busy_a), .done(done_a), .pulse_cnt(cnt_a), .period(per_a),
        .match(match_a), .overflow(ovf_a)
    );

    pulse_train_rx #(.CNT_W(3), .IDLE_TIMEOUT(T), .EXP_PULSES(EXP)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .pulse_in(pulse_in), .clr(clr),
        .busy(busy_b), .done(done_b), .pulse_cnt(cnt_b), .period(per_b),
        .match(match_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int burst_id = 0;
    int rise_q[$];
    int start_a, start_b;

    int dn_a = 0, dn_b = 0;
    int dn_edge_a = -1, dn_edge_b = -1;
    longint s_cnt_a, s_per_a, s_match_a, s_ovf_a, s_busy_a;
    longint s_cnt_b, s_per_b, s_match_b, s_ovf_b, s_busy_b;

    always @(negedge clk) begin
        if (done_a) begin
            dn_a++;
            dn_edge_a = cyc;
            s_cnt_a = cnt_a; s_per_a = per_a; s_match_a = match_a;
            s_ovf_a = ovf_a; s_busy_a = busy_a;
        end
        if (done_b) begin
            dn_b++;
            dn_edge_b = cyc;
            s_cnt_b = cnt_b; s_per_b = per_b; s_match_b = match_b;
            s_ovf_b = ovf_b; s_busy_b = busy_b;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (burst %0d): got %0d, expected %0d", name, burst_id, act, exp);
        end
    endtask

    // Rise edges are recorded as the tick count at which pulse_in went high.
    task automatic drive_burst(input int n, input int h, input int l, input bit rnd);
        int hh, ll;
        burst_id++;
        rise_q.delete();
        start_a = dn_a;
        start_b = dn_b;
        for (int i = 0; i < n; i++) begin
            hh = rnd ? int'($urandom_range(8, 1)) : h;
            ll = rnd ? int'($urandom_range(40, 1)) : l;
            pulse_in = 1'b1;
            rise_q.push_back(cyc);
            repeat (hh) tick();
            pulse_in = 1'b0;
            repeat (ll) tick();
        end
    endtask

    task automatic check_burst(input int e_cnt, input int e_per, input int e_mt,
                               input int e_cnt_b, input int e_ovf_b, input int e_mt_b);
        int last;
        last = rise_q[rise_q.size() - 1];
        while (cyc < last + 3) tick();
        check("busy_mid", busy_a, 1);
        check("cnt_mid", cnt_a, e_cnt);
        check("cnt_mid_b", cnt_b, e_cnt_b);
        for (int k = 0; k < T + 20 && dn_a == start_a; k++) tick();
        tick();
        tick();
        check("done_once", dn_a - start_a, 1);
        check("done_once_b", dn_b - start_b, 1);
        check("done_latency", dn_edge_a, last + 3 + T);
        check("done_latency_b", dn_edge_b, last + 3 + T);
        check("cnt_at_done", s_cnt_a, e_cnt);
        check("period_at_done", s_per_a, e_per);
        check("match_at_done", s_match_a, e_mt);
        check("ovf_at_done", s_ovf_a, 0);
        check("busy_at_done", s_busy_a, 0);
        check("cnt_at_done_b", s_cnt_b, e_cnt_b);
        check("period_at_done_b", s_per_b, e_per);
        check("ovf_at_done_b", s_ovf_b, e_ovf_b);
        check("match_at_done_b", s_match_b, e_mt_b);
        check("busy_after", busy_a, 0);
        check("cnt_held", cnt_a, e_cnt);
        check("period_held", per_a, e_per);
    endtask

    typedef struct {
        int n; int h; int l;
        int cnt; int per; int mt;
        int cnt_b; int ovf_b; int mt_b;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, e_per;

        vecs[0] = '{4, 5, 5,  4, 10, 1,  4, 0, 1};
        vecs[1] = '{1, 3, 5,  1,  0, 0,  1, 0, 0};
        vecs[2] = '{9, 5, 5,  9, 10, 0,  7, 1, 0};
        vecs[3] = '{3, 5, 59, 3, 64, 0,  3, 0, 0};
        vecs[4] = '{4, 1, 1,  4,  2, 1,  4, 0, 1};
        vecs[5] = '{8, 2, 7,  8,  9, 0,  7, 1, 0};
        vecs[6] = '{7, 4, 3,  7,  7, 0,  7, 0, 0};

        repeat (3) tick();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_period", per_a, 0);
        check("rst_match", match_a, 0);
        check("rst_ovf", ovf_a, 0);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 7; i++) begin
            drive_burst(vecs[i].n, vecs[i].h, vecs[i].l, 1'b0);
            check_burst(vecs[i].cnt, vecs[i].per, vecs[i].mt,
                        vecs[i].cnt_b, vecs[i].ovf_b, vecs[i].mt_b);
            repeat (4) tick();
        end

        // clr mid-burst: results zeroed, burst never completes
        drive_burst(2, 5, 5, 1'b0);
        while (cyc < rise_q[1] + 3) tick();
        check("clr_pre_busy", busy_a, 1);
        check("clr_pre_cnt", cnt_a, 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", busy_a, 0);
        check("clr_cnt", cnt_a, 0);
        check("clr_period", per_a, 0);
        check("clr_cnt_b", cnt_b, 0);
        repeat (T + 20) tick();
        check("clr_no_done", dn_a - start_a, 0);
        check("clr_cnt_held", cnt_a, 0);

        // asynchronous reset between clock edges mid-burst
        drive_burst(2, 5, 5, 1'b0);
        while (cyc < rise_q[1] + 3) tick();
        check("arst_pre_busy", busy_a, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_cnt", cnt_a, 0);
        check("arst_period", per_a, 0);
        check("arst_cnt_b", cnt_b, 0);
        #1 rst = 1'b0;
        repeat (T + 20) tick();
        check("arst_no_done", dn_a - start_a, 0);
        drive_burst(3, 5, 5, 1'b0);
        check_burst(3, 10, 0, 3, 0, 0);
        repeat (4) tick();

        for (int r = 0; r < 12; r++) begin
            drive_burst(int'($urandom_range(10, 1)), 0, 0, 1'b1);
            n = rise_q.size();
            e_per = (n > 1) ? rise_q[n - 1] - rise_q[n - 2] : 0;
            check_burst(n, e_per, (n == EXP) ? 1 : 0,
                        (n > CMAX_B) ? CMAX_B : n, (n > CMAX_B) ? 1 : 0,
                        (n == EXP && n <= CMAX_B) ? 1 : 0);
            repeat (int'($urandom_range(6, 2))) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
